matmul_ctrl: RTL

MATMUL_CTRL -- requirements
Module: matmul_ctrl

---
 rtl/matmul_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/matmul_ctrl.sv
// Matrix-multiply sequencer: walks C = A x B row-major, reading A/B stores and writing C.
// Optional MATMUL_SATURATE_EN clamps written elements to 2^DW-1 instead of truncating.
module matmul_ctrl #(
  parameter int M  = 2,
  parameter int N  = 2,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] a_row,
  output logic [DW-1:0] a_col,
  input  logic [DW-1:0] a_data,
  output logic [DW-1:0] b_row,
  output logic [DW-1:0] b_col,
  input  logic [DW-1:0] b_data,
  output logic [DW-1:0] c_row,
  output logic [DW-1:0] c_col,
  output logic          c_wr_en,
  output logic [DW-1:0] c_data
);

  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = JW;
  localparam int AW = 2 * DW + ((N > 1) ? $clog2(N) : 1);

  typedef enum logic [1:0] {IDLE, CALC, WRITE, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [KW-1:0] k_q, k_d;
  logic [AW-1:0] acc_q, acc_d;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          c_wr_en_q, c_wr_en_d;
  logic [DW-1:0] a_row_q, a_row_d, a_col_q, a_col_d;
  logic [DW-1:0] b_row_q, b_row_d, b_col_q, b_col_d;
  logic [DW-1:0] c_row_q, c_row_d, c_col_q, c_col_d;
  logic [DW-1:0] c_data_q, c_data_d;
  logic [DW-1:0] result;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      CALC: begin
        acc_d = ((k_q == '0) ? '0 : acc_q) + AW'(a_data) * AW'(b_data);
        if (k_q == KW'(N - 1)) begin
          state_d = WRITE;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      WRITE: begin
        state_d = CALC;
        k_d     = '0;
        if (j_q == JW'(N - 1)) begin
          j_d = '0;
          if (i_q == IW'(M - 1)) begin
            state_d = DONE;
            i_d     = '0;
          end else begin
            i_d = i_q + IW'(1);
          end
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Element value presented on a C write; acc_d already holds the finished sum.
  always_comb begin
`ifdef MATMUL_SATURATE_EN
    result = (acc_d > AW'({DW{1'b1}})) ? {DW{1'b1}} : acc_d[DW-1:0];
`else
    result = acc_d[DW-1:0];
`endif
  end

  // Outputs are derived from the next state so the registered values line up with the state.
  always_comb begin
    busy_d    = (state_d == CALC) || (state_d == WRITE);
    done_d    = (state_d == DONE);
    c_wr_en_d = (state_d == WRITE);
    a_row_d   = (state_d == CALC)  ? DW'(i_d) : '0;
    a_col_d   = (state_d == CALC)  ? DW'(k_d) : '0;
    b_row_d   = (state_d == CALC)  ? DW'(k_d) : '0;
    b_col_d   = (state_d == CALC)  ? DW'(j_d) : '0;
    c_row_d   = (state_d == WRITE) ? DW'(i_d) : '0;
    c_col_d   = (state_d == WRITE) ? DW'(j_d) : '0;
    c_data_d  = (state_d == WRITE) ? result   : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      c_wr_en_q <= 1'b0;
      a_row_q   <= '0;
      a_col_q   <= '0;
      b_row_q   <= '0;
      b_col_q   <= '0;
      c_row_q   <= '0;
      c_col_q   <= '0;
      c_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      c_wr_en_q <= c_wr_en_d;
      a_row_q   <= a_row_d;
      a_col_q   <= a_col_d;
      b_row_q   <= b_row_d;
      b_col_q   <= b_col_d;
      c_row_q   <= c_row_d;
      c_col_q   <= c_col_d;
      c_data_q  <= c_data_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign c_wr_en = c_wr_en_q;
  assign a_row   = a_row_q;
  assign a_col   = a_col_q;
  assign b_row   = b_row_q;
  assign b_col   = b_col_q;
  assign c_row   = c_row_q;
  assign c_col   = c_col_q;
  assign c_data  = c_data_q;

endmodule
